bsg_fifo_piso_drain: RTL
========================

// Module: bsg_fifo_piso_drain
// PURPOSE
//  Downstream consumer of bsg_fifo_1r1w_small_unhardened: drains the FIFO head word (els_p x width_p)
//  and emits it as a stream of width_p flits on a valid/ready_and link, lowest slice first.
//  Flit count per word comes from the word's len field.
//  Pops the FIFO (yumi_o) only when the last flit is accepted.
//  No local data storage: slices are taken from the FIFO head, which the FIFO holds stable until yumi.
// PARAMETERS
//  width_p  8  flit width in bits
//  els_p    4  max flits per FIFO word; >=2
//  lg_els_lp  $clog2(els_p+1)  width of len field (derived, not overridable)
// PORTS
//  clk_i        in   1                    single clock
//  reset_i      in   1                    synchronous, active-high reset
//  v_i          in   1                    FIFO head valid
//  data_i       in   els_p*width_p        FIFO head word; slice k = data_i[k*width_p+:width_p]
//  len_i        in   lg_els_lp            flits to send for this word, 1..els_p
//  yumi_o       out  1                    pop FIFO head (same-cycle, combinational)
//  v_o          out  1                    flit valid
//  data_o       out  width_p              current flit
//  last_o       out  1                    current flit is last of word
//  ready_and_i  in   1                    downstream accepts flit when v_o & ready_and_i
//  busy_o       out  1                    mid-word (idx_r != 0)
// BEHAVIOUR
//  - State: idx_r (lg_els_lp bits), index of next slice; reset/idle value 0. No other state.
//  - v_o = v_i & ~reset_i; data_o = slice[idx_r]; last_o = v_o & (idx_r == eff_len-1).
//  - eff_len = (len_i==0) ? 1 : min(len_i, els_p); len_i==0 or >els_p is illegal, flagged by assertion.
//  - Flit accepted (v_o & ready_and_i): if last_o then idx_r<=0, yumi_o=1 same cycle; else idx_r<=idx_r+1.
//  - yumi_o = v_o & ready_and_i & last_o; never asserted with v_i=0 (FIFO contract).
//  - Latency 0: first flit valid the same cycle v_i rises. One flit/cycle throughput.
//  - Back-to-back words: no bubble; next head's slice 0 presented the cycle after yumi_o.
//  - ready_and_i low: idx_r, data_o, v_o held; v_o must not drop while v_i=1.
//  - v_i drop mid-word (idx_r!=0): FIFO protocol violation; assertion fires; idx_r held.
//  - len_i must be stable while busy_o=1 (assertion).
//  - reset_i: idx_r<=0 next edge, overriding any acceptance that cycle.
//    During reset v_o=0, yumi_o=0, last_o=0, busy_o=0; partial word is restarted from slice 0 after reset.
//  - Outputs with v_o=0: data_o don't-care, last_o=0, yumi_o=0.
//  - FIFO empty (v_i=0) with idx_r=0: v_o=0, idle, no state change.
// STRUCTURE
//  - bsg_noc_pkg: add flit_len_width(els) function; no typedefs needed beyond it.
//  - One sub-module: bsg_counter_clear_up (max_val_p=els_p-1) for idx_r;
//    clear=yumi_o|reset_i, up=accept&~last_o.
//  - Slice mux: bsg_mux, els_p inputs.
//  - SVA bind file (fifo_sva_piso_drain): yumi_o->v_i; idx_r<eff_len; data_i/len_i stable while busy_o;
//    sum(yumi_o) == count of last_o acceptances.
// TESTING  (width_p=8, els_p=4, bench drives bsg_fifo_1r1w_small_unhardened -> DUT)
//  1 reset 3 cycles, FIFO empty -> v_o=0, yumi_o=0, busy_o=0 throughout.
//  2 push {44,33,22,11},len=4; ready_and_i=1
//    -> data_o 11,22,33,44 on cycles 0..3; last_o,yumi_o on cycle 3 only.
//  3 push two words len=2 ({..,B,A}) then len=3 ({..,E,D,C}), ready=1
//    -> A,B,C,D,E in 5 consecutive cycles; yumi_o cycles 1 and 4.
//  4 len=4 word, ready_and_i pattern 1,0,0,1,1,0,1
//    -> flits advance only on ready; data_o held when 0; yumi_o on 7th cycle.
//  5 len=3 word, reset_i pulsed after 2nd flit accepted
//    -> no yumi_o; after reset, slice 0 replayed, 3 flits then yumi_o; FIFO count decrements by 1.
//  6 len=1 words x4 back-to-back, ready=1
//    -> 4 flits in 4 cycles, last_o=yumi_o=1 each cycle, FIFO empty after.

Source files
------------

// File: rtl/bsg_fifo_piso_drain_pkg.sv
// Shared helpers for the FIFO parallel-in/serial-out drain block.
package bsg_fifo_piso_drain_pkg;

    // Width of a flit-count field able to hold 0..els inclusive.
    function automatic int flit_len_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; wraps to zero past max_val_p.
module bsg_counter_clear_up
    import bsg_fifo_piso_drain_pkg::*;
#(
    parameter int max_val_p = 3,
    parameter int width_p   = flit_len_width(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] MaxLp = width_p'(max_val_p);

    logic [width_p-1:0] r_count;

    // Clear (or reset) wins over increment; increment past max wraps to 0.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            r_count <= '0;
        end else if (up_i) begin
            r_count <= (r_count == MaxLp) ? '0 : r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/bsg_fifo_piso_drain.sv
// Drains the FIFO head word as a stream of width_p flits, lowest slice
// first. Holds no data: slices are muxed straight off the FIFO head, which
// stays stable until yumi_o pops it on the last accepted flit.
module bsg_fifo_piso_drain
    import bsg_fifo_piso_drain_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int lg_els_lp = flit_len_width(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [lg_els_lp-1:0]     len_i,
    output logic                     yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     last_o,
    input  logic                     ready_and_i,
    output logic                     busy_o
);

    localparam logic [lg_els_lp-1:0] ElsLp = lg_els_lp'(els_p);

    logic [lg_els_lp-1:0] w_idx;
    logic [lg_els_lp-1:0] w_eff_len;
    logic                 w_accept;
    logic                 w_clear;
    logic                 w_up;

    // Illegal lengths are clamped so the stream always terminates.
    always_comb begin
        w_eff_len = len_i;
        if (len_i == '0) begin
            w_eff_len = lg_els_lp'(1);
        end else if (len_i > ElsLp) begin
            w_eff_len = ElsLp;
        end
    end

    assign v_o      = v_i & ~reset_i;
    assign last_o   = v_o & (w_idx == (w_eff_len - 1'b1));
    assign w_accept = v_o & ready_and_i;
    assign yumi_o   = w_accept & last_o;
    assign busy_o   = (w_idx != '0) & ~reset_i;

    // Reset restarts any partial word from slice 0.
    assign w_clear  = yumi_o | reset_i;
    assign w_up     = w_accept & ~last_o;

    bsg_counter_clear_up #(
        .max_val_p (els_p - 1),
        .width_p   (lg_els_lp)
    ) u_idx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (w_clear),
        .up_i    (w_up),
        .count_o (w_idx)
    );

    // Slice select off the FIFO head.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < els_p; k++) begin
            if (w_idx == lg_els_lp'(k)) begin
                data_o = data_i[k*width_p +: width_p];
            end
        end
    end

    // Protocol checks on the FIFO side of the link.
    a_yumi_needs_v: assert property (@(posedge clk_i) yumi_o |-> v_i);

    a_len_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        v_i |-> (len_i != '0) && (len_i <= ElsLp));

    a_idx_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        v_i |-> (w_idx < w_eff_len));

    a_no_drop_midword: assert property (@(posedge clk_i) disable iff (reset_i)
        (w_idx != '0) |-> v_i);

    a_head_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o && !yumi_o) |=> ($stable(len_i) && $stable(data_i)));

    a_yumi_is_last_accept: assert property (@(posedge clk_i)
        yumi_o == (w_accept && last_o));

endmodule
